alu_share_arb: RTL and testbench

//  Shares one combinational ALU between two requesters (port 0, port 1).

---
 rtl/alu_share_arb.sv | 180 ++++++++++++++++++
 tb/tb_alu_share_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// ============================================================================
// Module   : alu_share_arb
// Purpose  : Round-robin share of one combinational ALU between two requesters;
//            registered operand issue and held valid/ready response.
//            Optional opcode screening when ALU_ARB_OPCHECK_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_share_arb #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
`ifdef ALU_ARB_OPCHECK_EN
  output logic             rsp_err,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
`ifdef ALU_ARB_OPCHECK_EN
  logic             err_q, err_d;
`endif

  logic             sel1;
  logic             any_valid;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [OPW-1:0]   sel_op;

  // Port 1 wins when it is the only requester or when the pointer favours it.
  assign sel1      = req1_valid && (!req0_valid || rr_ptr_q);
  assign any_valid = req0_valid || req1_valid;
  assign sel_a     = sel1 ? req1_a  : req0_a;
  assign sel_b     = sel1 ? req1_b  : req0_b;
  assign sel_op    = sel1 ? req1_op : req0_op;

  assign req0_ready = !reset && (state_q == S_IDLE) && req0_valid && !sel1;
  assign req1_ready = !reset && (state_q == S_IDLE) && sel1;

`ifdef ALU_ARB_OPCHECK_EN
  function automatic logic op_legal(input logic [OPW-1:0] op);
    logic ok;
    case (op)
      OPW'(0), OPW'(1), OPW'(2), OPW'(3), OPW'(6): ok = 1'b1;
      default:                                     ok = 1'b0;
    endcase
    return ok;
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    id_d     = id_q;
    res_d    = res_q;
    zero_d   = zero_q;
`ifdef ALU_ARB_OPCHECK_EN
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          id_d = sel1;
`ifdef ALU_ARB_OPCHECK_EN
          if (op_legal(sel_op)) begin
            alu_a_d  = sel_a;
            alu_b_d  = sel_b;
            alu_op_d = sel_op;
            err_d    = 1'b0;
            state_d  = S_EXEC;
          end else begin
            // Rejected opcode never reaches the ALU; the response reports it.
            err_d   = 1'b1;
            res_d   = '0;
            zero_d  = 1'b0;
            state_d = S_RESP;
          end
`else
          alu_a_d  = sel_a;
          alu_b_d  = sel_b;
          alu_op_d = sel_op;
          state_d  = S_EXEC;
`endif
        end
      end
      S_EXEC: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = ~id_q;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      id_q     <= 1'b0;
      res_q    <= '0;
      zero_q   <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      id_q     <= id_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
`ifdef ALU_ARB_OPCHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
`ifdef ALU_ARB_OPCHECK_EN
  assign rsp_err    = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arb.sv
// ============================================================================
// Module   : tb_alu_share_arb
// Purpose  : Directed self-checking bench for alu_share_arb with a behavioural ALU.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_share_arb;

  logic        clk;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [31:0] rsp_result;
`ifdef ALU_ARB_OPCHECK_EN
  logic        rsp_err;
`endif

  int checks = 0;
  int errors = 0;

  alu_share_arb #(.WIDTH(32), .OPW(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
`ifdef ALU_ARB_OPCHECK_EN
    .rsp_err(rsp_err),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  // Behavioural ALU; 111 acts as set-less-than.
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a & alu_b;
      3'b001:  alu_result = alu_a | alu_b;
      3'b010:  alu_result = alu_a + alu_b;
      3'b011:  alu_result = alu_b << 16;
      3'b110:  alu_result = alu_a - alu_b;
      3'b111:  alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    tick();
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b exp 00", req0_ready, req1_ready); end
    checks++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_rsp: got v=%b id=%b z=%b exp 0", rsp_valid, rsp_id, rsp_zero); end
    checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h exp 0", rsp_result); end
    checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 3'd0) begin errors++; $display("FAIL reset_alu: got %h %h %h exp 0", alu_a, alu_b, alu_op); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_port0();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 3'b010;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL p0_ready: got %b%b exp 10", req0_ready, req1_ready); end
    tick();
    req0_valid = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || req0_ready !== 1'b0) begin errors++; $display("FAIL p0_exec: got v=%b rdy=%b exp 0 0", rsp_valid, req0_ready); end
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_op !== 3'b010) begin errors++; $display("FAIL p0_issue: got %h %h %h exp 5 3 2", alu_a, alu_b, alu_op); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin errors++; $display("FAIL p0_rsp: got v=%b id=%b exp 1 0", rsp_valid, rsp_id); end
    checks++; if (rsp_result !== 32'd8 || rsp_zero !== 1'b0) begin errors++; $display("FAIL p0_result: got %h z=%b exp 8 0", rsp_result, rsp_zero); end
`ifdef ALU_ARB_OPCHECK_EN
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL p0_err: got %b exp 0", rsp_err); end
`endif
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL p0_done: got %b exp 0", rsp_valid); end
  endtask

  task automatic test_both();
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd7;    req0_b = 32'd7;    req0_op = 3'b110;
    req1_valid = 1'b1; req1_a = 32'hF0;   req1_b = 32'h0F;   req1_op = 3'b001;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL both_first: got %b%b exp 10", req0_ready, req1_ready); end
    tick();
    req0_valid = 1'b0;
    #1;
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL both_exec_ready: got %b exp 0", req1_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd0 || rsp_zero !== 1'b1) begin errors++; $display("FAIL both_rsp0: got v=%b id=%b r=%h z=%b exp 1 0 0 1", rsp_valid, rsp_id, rsp_result, rsp_zero); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL both_resp_ready: got %b exp 0", req1_ready); end
    tick();
    checks++; if (req1_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL both_second: got rdy=%b v=%b exp 1 0", req1_ready, rsp_valid); end
    tick();
    req1_valid = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'hFF || rsp_zero !== 1'b0) begin errors++; $display("FAIL both_rsp1: got v=%b id=%b r=%h z=%b exp 1 1 ff 0", rsp_valid, rsp_id, rsp_result, rsp_zero); end
    tick();
  endtask

  task automatic test_fairness();
    int grants = 0;
    int rsps = 0;
    int g;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd23;  req0_op = 3'b010;
    req1_valid = 1'b1; req1_a = 32'hFF;  req1_b = 32'h3C;  req1_op = 3'b000;
    #1;
    for (int cyc = 0; cyc < 40 && grants < 6; cyc++) begin
      g = -1;
      if (req0_ready === 1'b1) g = 0;
      else if (req1_ready === 1'b1) g = 1;
      if (g >= 0) begin
        checks++; if (g != (grants % 2)) begin errors++; $display("FAIL fair_grant%0d: got port %0d exp port %0d", grants, g, grants % 2); end
        grants++;
      end
      if (rsp_valid === 1'b1) begin
        checks++;
        if (rsp_id !== rsp_id_exp(rsps) || rsp_result !== (rsps % 2 == 0 ? 32'd123 : 32'h3C)) begin
          errors++; $display("FAIL fair_rsp%0d: got id=%b r=%h exp id=%0d r=%h", rsps, rsp_id, rsp_result, rsps % 2, (rsps % 2 == 0 ? 32'd123 : 32'h3C));
        end
        rsps++;
      end
      tick();
    end
    checks++; if (grants != 6) begin errors++; $display("FAIL fair_count: got %0d grants exp 6", grants); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    tick();
  endtask

  function automatic logic rsp_id_exp(input int n);
    return (n % 2 == 1);
  endfunction

  task automatic test_hold();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_op = 3'b010;
    #1;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_op = 3'b000;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd30 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || alu_op !== 3'b010 || alu_a !== 32'd10) begin
        errors++; $display("FAIL hold_cyc%0d: got v=%b id=%b r=%h rdy=%b%b op=%h a=%h exp 1 0 1e 00 2 a", i, rsp_valid, rsp_id, rsp_result, req0_ready, req1_ready, alu_op, alu_a);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    req0_valid = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL hold_rr: got %b%b exp 01", req0_ready, req1_ready); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'd1) begin errors++; $display("FAIL hold_p1: got v=%b id=%b r=%h exp 1 1 1", rsp_valid, rsp_id, rsp_result); end
    tick();
  endtask

  task automatic test_reset_exec();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b010;
    #1;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd4; req1_op = 3'b010;
    #1;
    tick();
    req1_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || alu_a !== 32'd0 || alu_op !== 3'd0 || rsp_result !== 32'd0) begin errors++; $display("FAIL rst_exec_async: got v=%b a=%h op=%h r=%h exp 0", rsp_valid, alu_a, alu_op, rsp_result); end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_exec_norsp%0d: got %b exp 0", i, rsp_valid); end
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rst_exec_rrptr: got %b%b exp 10", req0_ready, req1_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
  endtask

  task automatic test_opcode();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd5; req0_op = 3'b111;
    #1;
    tick();
    req0_valid = 1'b0;
    #1;
`ifdef ALU_ARB_OPCHECK_EN
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL opchk_err: got v=%b err=%b exp 1 1", rsp_valid, rsp_err); end
    checks++; if (rsp_result !== 32'd0 || rsp_zero !== 1'b0 || alu_op !== 3'd0) begin errors++; $display("FAIL opchk_data: got r=%h z=%b op=%h exp 0 0 0", rsp_result, rsp_zero, alu_op); end
`else
    checks++; if (alu_op !== 3'b111 || rsp_valid !== 1'b0) begin errors++; $display("FAIL opraw_issue: got op=%h v=%b exp 7 0", alu_op, rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd1 || rsp_zero !== 1'b0) begin errors++; $display("FAIL opraw_rsp: got v=%b r=%h z=%b exp 1 1 0", rsp_valid, rsp_result, rsp_zero); end
`endif
    tick();
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    test_reset();
    test_port0();
    test_both();
    test_fairness();
    test_hold();
    test_reset_exec();
    test_opcode();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
